// File: rtl/block_ram_dual_be_if.sv
// One RAM port: independent read and byte-enabled write channels plus read-data return.
// DO/DO_VALID flow back to the master; everything else is driven by the master.
interface block_ram_dual_be_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] RD_ADDR;
  logic                  RE;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] DI;
  logic                  WE;
  logic [NBYTES-1:0]     BE;
  logic [DATA_WIDTH-1:0] DO;
  logic                  DO_VALID;

  modport master (
    output RD_ADDR, RE, WR_ADDR, DI, WE, BE,
    input  DO, DO_VALID
  );

  modport slave (
    input  RD_ADDR, RE, WR_ADDR, DI, WE, BE,
    output DO, DO_VALID
  );
endinterface

// File: rtl/block_ram_dual_be.sv
// Dual-port block RAM with per-port byte-enabled writes, A-wins byte merge on same-address
// writes, selectable read-during-write behaviour and an optional output register stage.
module block_ram_dual_be #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter     INIT_FILE  = "UNUSED",
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  block_ram_dual_be_if.slave   port_a,
  block_ram_dual_be_if.slave   port_b,
  output logic                 COLLIDE
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  // Index 0 is port A, index 1 is port B.
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [ADDR_WIDTH-1:0] wr_addr [2];
  logic [DATA_WIDTH-1:0] di      [2];
  logic [NBYTES-1:0]     be      [2];
  logic                  re      [2];
  logic                  we      [2];
  logic [1:0]            we_eff;
  logic [DATA_WIDTH-1:0] do_w       [2];
  logic                  do_valid_w [2];

  assign rd_addr[0] = port_a.RD_ADDR;
  assign rd_addr[1] = port_b.RD_ADDR;
  assign wr_addr[0] = port_a.WR_ADDR;
  assign wr_addr[1] = port_b.WR_ADDR;
  assign di[0]      = port_a.DI;
  assign di[1]      = port_b.DI;
  assign be[0]      = port_a.BE;
  assign be[1]      = port_b.BE;
  assign re[0]      = port_a.RE;
  assign re[1]      = port_b.RE;
  assign we[0]      = port_a.WE;
  assign we[1]      = port_b.WE;

  assign port_a.DO       = do_w[0];
  assign port_b.DO       = do_w[1];
  assign port_a.DO_VALID = do_valid_w[0];
  assign port_b.DO_VALID = do_valid_w[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  genvar gi;
  generate
    // A write with no byte enabled is not a write at all, and nothing is written in reset.
    for (gi = 0; gi < 2; gi++) begin : g_we
      assign we_eff[gi] = we[gi] & reset & (|be[gi]);
    end
  endgenerate

  // Port A is applied last so it wins any byte both ports write in the same cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (we_eff[1] && be[1][i]) mem[wr_addr[1]][8*i +: 8] <= di[1][8*i +: 8];
      if (we_eff[0] && be[0][i]) mem[wr_addr[0]][8*i +: 8] <= di[0][8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      COLLIDE <= 1'b0;
    end else begin
      COLLIDE <= we_eff[0] && we_eff[1] && (wr_addr[0] == wr_addr[1]) && (|(be[0] & be[1]));
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_WIDTH-1:0] rd_word_reg;
      logic [DATA_WIDTH-1:0] fwd_data_reg;
      logic [NBYTES-1:0]     fwd_mask_reg;
      logic [DATA_WIDTH-1:0] fwd_data_next;
      logic [NBYTES-1:0]     fwd_mask_next;
      logic [DATA_WIDTH-1:0] merged;
      logic [DATA_WIDTH-1:0] hold_reg;
      logic                  s1_valid_reg;
      logic                  s2_valid_reg;

      // Bytes written this cycle to the read address, resolved with the same A-over-B priority.
      always_comb begin
        fwd_mask_next = '0;
        fwd_data_next = '0;
        for (int i = 0; i < NBYTES; i++) begin
          if (we_eff[0] && be[0][i] && (wr_addr[0] == rd_addr[gi])) begin
            fwd_mask_next[i]          = 1'b1;
            fwd_data_next[8*i +: 8]   = di[0][8*i +: 8];
          end else if (we_eff[1] && be[1][i] && (wr_addr[1] == rd_addr[gi])) begin
            fwd_mask_next[i]          = 1'b1;
            fwd_data_next[8*i +: 8]   = di[1][8*i +: 8];
          end
        end
        if (RDW_MODE == 0) fwd_mask_next = '0;
      end

      // Read-first RAM access; forwarding is merged after the registered read.
      always_ff @(posedge clock) begin
        if (re[gi]) begin
          rd_word_reg  <= mem[rd_addr[gi]];
          fwd_mask_reg <= fwd_mask_next;
          fwd_data_reg <= fwd_data_next;
        end
      end

      always_comb begin
        merged = rd_word_reg;
        for (int i = 0; i < NBYTES; i++) begin
          if (fwd_mask_reg[i]) merged[8*i +: 8] = fwd_data_reg[8*i +: 8];
        end
      end

      // hold_reg doubles as the output pipeline stage and the last-value holder.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          s1_valid_reg <= 1'b0;
          s2_valid_reg <= 1'b0;
          hold_reg     <= '0;
        end else begin
          s1_valid_reg <= re[gi];
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) hold_reg <= merged;
        end
      end

      assign do_w[gi]       = (OUT_REG != 0) ? hold_reg : (s1_valid_reg ? merged : hold_reg);
      assign do_valid_w[gi] = (OUT_REG != 0) ? s2_valid_reg : s1_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_dual_be.sv
// Directed bench: two RAM instances (old-data/no out reg, forwarded/out reg) driven in lockstep.
module tb_block_ram_dual_be;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clock;
  logic reset;
  logic collide0, collide1;
  int   n_checks;
  int   n_pass;

  block_ram_dual_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a0 ();
  block_ram_dual_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b0 ();
  block_ram_dual_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a1 ();
  block_ram_dual_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b1 ();

  assign if_a1.RD_ADDR = if_a0.RD_ADDR;
  assign if_a1.RE      = if_a0.RE;
  assign if_a1.WR_ADDR = if_a0.WR_ADDR;
  assign if_a1.DI      = if_a0.DI;
  assign if_a1.WE      = if_a0.WE;
  assign if_a1.BE      = if_a0.BE;
  assign if_b1.RD_ADDR = if_b0.RD_ADDR;
  assign if_b1.RE      = if_b0.RE;
  assign if_b1.WR_ADDR = if_b0.WR_ADDR;
  assign if_b1.DI      = if_b0.DI;
  assign if_b1.WE      = if_b0.WE;
  assign if_b1.BE      = if_b0.BE;

  block_ram_dual_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_FILE("UNUSED"),
                      .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clock(clock), .reset(reset), .port_a(if_a0), .port_b(if_b0), .COLLIDE(collide0));

  block_ram_dual_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_FILE("UNUSED"),
                      .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clock(clock), .reset(reset), .port_a(if_a1), .port_b(if_b1), .COLLIDE(collide1));

  // [instance][port]: instance 0 = old data, 1-cycle latency; instance 1 = forwarded, 2-cycle.
  logic [DW-1:0] dout [2][2];
  logic          dval [2][2];
  logic          coll [2];

  assign dout[0][0] = if_a0.DO;
  assign dout[0][1] = if_b0.DO;
  assign dout[1][0] = if_a1.DO;
  assign dout[1][1] = if_b1.DO;
  assign dval[0][0] = if_a0.DO_VALID;
  assign dval[0][1] = if_b0.DO_VALID;
  assign dval[1][0] = if_a1.DO_VALID;
  assign dval[1][1] = if_b1.DO_VALID;
  assign coll[0]    = collide0;
  assign coll[1]    = collide1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    if_a0.RE = 1'b0; if_a0.WE = 1'b0; if_a0.BE = '0;
    if_a0.RD_ADDR = '0; if_a0.WR_ADDR = '0; if_a0.DI = '0;
    if_b0.RE = 1'b0; if_b0.WE = 1'b0; if_b0.BE = '0;
    if_b0.RD_ADDR = '0; if_b0.WR_ADDR = '0; if_b0.DI = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic [3:0] bytes);
    if (p == 0) begin
      if_a0.WE = 1'b1; if_a0.WR_ADDR = addr; if_a0.DI = data; if_a0.BE = bytes;
    end else begin
      if_b0.WE = 1'b1; if_b0.WR_ADDR = addr; if_b0.DI = data; if_b0.BE = bytes;
    end
  endtask

  task automatic rd(input int p, input logic [AW-1:0] addr);
    if (p == 0) begin
      if_a0.RE = 1'b1; if_a0.RD_ADDR = addr;
    end else begin
      if_b0.RE = 1'b1; if_b0.RD_ADDR = addr;
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    wr(0, 5'd0, 32'hDEADBEEF, 4'hF);
    wr(1, 5'd0, 32'h01020304, 4'hF);
    rd(0, 5'd0);
    rd(1, 5'd1);
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (coll[d] !== 1'b0) $display("FAIL reset_collide dut%0d: got %b want 0", d, coll[d]);
      else n_pass++;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (dout[d][p] !== '0) $display("FAIL reset_do dut%0d port%0d: got %h want 0", d, p, dout[d][p]);
        else n_pass++;
        n_checks++;
        if (dval[d][p] !== 1'b0) $display("FAIL reset_valid dut%0d port%0d: got %b want 0", d, p, dval[d][p]);
        else n_pass++;
      end
    end
    idle();
    reset = 1'b1;
  endtask

  // Reads start on the very first edge after release; address 0 also proves the reset-time write was dropped.
  task automatic test_init_zero();
    logic exp_v;
    for (int k = 0; k < 34; k++) begin
      idle();
      if (k < 32) begin
        rd(0, 5'(k));
        rd(1, 5'(31 - k));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          exp_v = (d == 0) ? (k < 32) : (k >= 1 && k <= 32);
          n_checks++;
          if (dval[d][p] !== exp_v) $display("FAIL init_valid k%0d dut%0d port%0d: got %b want %b", k, d, p, dval[d][p], exp_v);
          else n_pass++;
          if (exp_v) begin
            n_checks++;
            if (dout[d][p] !== '0) $display("FAIL init_zero k%0d dut%0d port%0d: got %h want 0", k, d, p, dout[d][p]);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    idle(); wr(0, 5'd5, 32'h11223344, 4'hF); tick();
    idle(); wr(0, 5'd5, 32'hAABBCCDD, 4'h5); tick();
    idle(); rd(1, 5'd5); tick();
    n_checks++;
    if (dval[0][1] !== 1'b1 || dout[0][1] !== 32'h11BB33DD)
      $display("FAIL be_lat1 dut0: valid %b data %h want 1 11bb33dd", dval[0][1], dout[0][1]);
    else n_pass++;
    n_checks++;
    if (dval[1][1] !== 1'b0) $display("FAIL be_early dut1: valid %b want 0", dval[1][1]);
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (dval[0][1] !== 1'b0 || dout[0][1] !== 32'h11BB33DD)
      $display("FAIL be_hold dut0: valid %b data %h want 0 11bb33dd", dval[0][1], dout[0][1]);
    else n_pass++;
    n_checks++;
    if (dval[1][1] !== 1'b1 || dout[1][1] !== 32'h11BB33DD)
      $display("FAIL be_lat2 dut1: valid %b data %h want 1 11bb33dd", dval[1][1], dout[1][1]);
    else n_pass++;
    tick();
    n_checks++;
    if (dval[1][1] !== 1'b0 || dout[1][1] !== 32'h11BB33DD)
      $display("FAIL be_hold dut1: valid %b data %h want 0 11bb33dd", dval[1][1], dout[1][1]);
    else n_pass++;
  endtask

  // A's write to address 3 has no bytes enabled: it must neither forward nor collide.
  task automatic test_rdw();
    idle();
    wr(1, 5'd3, 32'hFFFFFFFF, 4'hF);
    wr(0, 5'd3, 32'h12345678, 4'h0);
    rd(0, 5'd3);
    tick();
    n_checks++;
    if (dval[0][0] !== 1'b1 || dout[0][0] !== 32'h0)
      $display("FAIL rdw_old dut0: valid %b data %h want 1 00000000", dval[0][0], dout[0][0]);
    else n_pass++;
    n_checks++;
    if (coll[0] !== 1'b0 || coll[1] !== 1'b0)
      $display("FAIL rdw_no_collide: got %b%b want 00", coll[0], coll[1]);
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (dval[1][0] !== 1'b1 || dout[1][0] !== 32'hFFFFFFFF)
      $display("FAIL rdw_new dut1: valid %b data %h want 1 ffffffff", dval[1][0], dout[1][0]);
    else n_pass++;
    idle(); rd(0, 5'd3); tick();
    n_checks++;
    if (dout[0][0] !== 32'hFFFFFFFF) $display("FAIL rdw_stored dut0: got %h want ffffffff", dout[0][0]);
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (dout[1][0] !== 32'hFFFFFFFF) $display("FAIL rdw_stored dut1: got %h want ffffffff", dout[1][0]);
    else n_pass++;
  endtask

  task automatic test_collide();
    idle();
    wr(0, 5'd7, 32'h000000AA, 4'h1);
    wr(1, 5'd7, 32'hBBBBBBBB, 4'h3);
    rd(1, 5'd7);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (coll[d] !== 1'b1) $display("FAIL collide_hit dut%0d: got %b want 1", d, coll[d]);
      else n_pass++;
    end
    n_checks++;
    if (dout[0][1] !== 32'h0) $display("FAIL collide_old dut0: got %h want 00000000", dout[0][1]);
    else n_pass++;
    idle();
    wr(0, 5'd9, 32'h12345678, 4'hC);
    wr(1, 5'd9, 32'h9ABCDEF0, 4'h3);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (coll[d] !== 1'b0) $display("FAIL collide_disjoint dut%0d: got %b want 0", d, coll[d]);
      else n_pass++;
    end
    n_checks++;
    if (dval[1][1] !== 1'b1 || dout[1][1] !== 32'h0000BBAA)
      $display("FAIL collide_fwd dut1: valid %b data %h want 1 0000bbaa", dval[1][1], dout[1][1]);
    else n_pass++;
    idle();
    wr(0, 5'd10, 32'h0, 4'hF);
    wr(1, 5'd11, 32'h0, 4'hF);
    tick();
    n_checks++;
    if (coll[0] !== 1'b0 || coll[1] !== 1'b0)
      $display("FAIL collide_diff_addr: got %b%b want 00", coll[0], coll[1]);
    else n_pass++;
    idle(); rd(0, 5'd7); rd(1, 5'd9); tick();
    idle(); tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (dout[d][0] !== 32'h0000BBAA) $display("FAIL collide_merge dut%0d: got %h want 0000bbaa", d, dout[d][0]);
      else n_pass++;
      n_checks++;
      if (dout[d][1] !== 32'h1234DEF0) $display("FAIL collide_split dut%0d: got %h want 1234def0", d, dout[d][1]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int base [2];
    int cnt [2][2];
    int j;
    base[0] = 8;
    base[1] = 12;
    for (int a = 8; a < 28; a++) begin
      idle(); wr(0, 5'(a), pat(a), 4'hF); tick();
    end
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) cnt[d][p] = 0;
    for (int k = 0; k < 18; k++) begin
      idle();
      if (k < 16) begin
        rd(0, 5'(base[0] + k));
        rd(1, 5'(base[1] + k));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          j = k - d;
          if (dval[d][p] === 1'b1) cnt[d][p]++;
          n_checks++;
          if (dval[d][p] !== ((j >= 0) && (j < 16)))
            $display("FAIL b2b_valid k%0d dut%0d port%0d: got %b", k, d, p, dval[d][p]);
          else n_pass++;
          if (j >= 0 && j < 16) begin
            n_checks++;
            if (dout[d][p] !== pat(base[p] + j))
              $display("FAIL b2b_data k%0d dut%0d port%0d: got %h want %h", k, d, p, dout[d][p], pat(base[p] + j));
            else n_pass++;
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (cnt[d][p] !== 16) $display("FAIL b2b_count dut%0d port%0d: got %0d want 16", d, p, cnt[d][p]);
        else n_pass++;
      end
    end
  endtask

  // Reset lands while the read is still between the two output stages of instance 1.
  task automatic test_reset_midflight();
    idle(); rd(0, 5'd5); tick();
    idle();
    reset = 1'b0;
    wr(0, 5'd5, 32'h0, 4'hF);
    #1;
    n_checks++;
    if (dout[1][0] !== 32'h0 || dval[1][0] !== 1'b0 || dout[0][0] !== 32'h0)
      $display("FAIL midrst_force: dut1 %h/%b dut0 %h want 0/0 0", dout[1][0], dval[1][0], dout[0][0]);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (dval[1][0] !== 1'b0) $display("FAIL midrst_in_reset dut1: valid %b want 0", dval[1][0]);
    else n_pass++;
    idle();
    reset = 1'b1;
    tick();
    n_checks++;
    if (dval[1][0] !== 1'b0 || dout[1][0] !== 32'h0)
      $display("FAIL midrst_release1 dut1: valid %b data %h want 0 0", dval[1][0], dout[1][0]);
    else n_pass++;
    tick();
    n_checks++;
    if (dval[1][0] !== 1'b0) $display("FAIL midrst_release2 dut1: valid %b want 0", dval[1][0]);
    else n_pass++;
    idle(); rd(0, 5'd5); rd(1, 5'd8); tick();
    n_checks++;
    if (dout[0][0] !== 32'h11BB33DD || dout[0][1] !== pat(8))
      $display("FAIL midrst_retained dut0: got %h %h want 11bb33dd %h", dout[0][0], dout[0][1], pat(8));
    else n_pass++;
    idle(); tick();
    n_checks++;
    if (dout[1][0] !== 32'h11BB33DD || dout[1][1] !== pat(8))
      $display("FAIL midrst_retained dut1: got %h %h want 11bb33dd %h", dout[1][0], dout[1][1], pat(8));
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_init_zero();
    test_byte_enable();
    test_rdw();
    test_collide();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
